// File: rtl/dlx_fwd_scoreboard_pkg.sv
// dlx_fwd_scoreboard_pkg: shared encodings and entry-record layout for the forwarding scoreboard
package dlx_fwd_scoreboard_pkg;
  localparam int SEL_RF = 0;
  localparam int E_LD = 0;
  localparam int E_DST = 1;
  function automatic int e_vld(input int rbits);
    return rbits + 1;
  endfunction
endpackage

// File: rtl/dlx_fwd_match.sv
// dlx_fwd_match: priority-match of one source operand against all in-flight entries
module dlx_fwd_match
  import dlx_fwd_scoreboard_pkg::*;
#(
  parameter int RBITS = 5,
  parameter int DEPTH = 3,
  parameter int LOAD_RDY = 1,
  parameter int SELW = $clog2(DEPTH + 1)
) (
  input  logic                          en,
  input  logic [RBITS-1:0]              src,
  input  logic [DEPTH-1:0][RBITS+1:0]   ent,
  output logic [SELW-1:0]               sel,
  output logic                          hazard
);
  localparam int VB = e_vld(RBITS);
  // scan oldest to youngest so the youngest matching producer has the final word
  always_comb begin
    sel = SELW'(SEL_RF);
    hazard = 1'b0;
    for (int k = DEPTH - 1; k >= 0; k--)
      if (en && src != '0 && ent[k][VB] && ent[k][E_DST +: RBITS] == src) begin
        hazard = ent[k][E_LD] && (k < LOAD_RDY);
        sel = hazard ? SELW'(SEL_RF) : SELW'(k + 1);
      end
  end
endmodule

// File: rtl/dlx_fwd_scoreboard.sv
// dlx_fwd_scoreboard: shadow pipeline of in-flight destinations driving ID bypass selects and load-use interlock
module dlx_fwd_scoreboard
  import dlx_fwd_scoreboard_pkg::*;
#(
  parameter int RBITS = 5,
  parameter int DEPTH = 3,
  parameter int NSRC = 2,
  parameter int LOAD_RDY = 1,
  parameter int SELW = $clog2(DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   id_valid,
  input  logic                   id_dst_en,
  input  logic [RBITS-1:0]       id_dst,
  input  logic                   id_is_load,
  input  logic [NSRC-1:0]        id_src_en,
  input  logic [NSRC*RBITS-1:0]  id_src,
  input  logic                   mem_busy,
  input  logic                   flush,
  output logic [NSRC*SELW-1:0]   src_sel,
  output logic                   stall,
  output logic                   issue,
  output logic [15:0]            stall_cnt
);
  logic [DEPTH-1:0][RBITS+1:0] ent;
  logic [NSRC-1:0] hazard;
  genvar i;
  for (i = 0; i < NSRC; i++) begin : g_src
    dlx_fwd_match #(.RBITS(RBITS), .DEPTH(DEPTH), .LOAD_RDY(LOAD_RDY), .SELW(SELW)) u_match (
      .en(id_src_en[i]),
      .src(id_src[i*RBITS +: RBITS]),
      .ent(ent),
      .sel(src_sel[i*SELW +: SELW]),
      .hazard(hazard[i])
    );
  end
  assign stall = id_valid & |hazard & ~flush;
  assign issue = id_valid & ~stall & ~mem_busy & ~flush;
  // advance the shadow pipeline unless memory holds it; flush kills the ID instruction and EX
  always_ff @(posedge clk) begin
    if (reset) begin
      ent <= '0;
      stall_cnt <= '0;
    end else begin
      if (!mem_busy) begin
        for (int k = 1; k < DEPTH; k++) ent[k] <= (flush && k == 1) ? '0 : ent[k-1];
        ent[0] <= issue ? {id_dst_en & (id_dst != '0), id_dst, id_is_load} : '0;
      end
      if (stall && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
    end
  end
endmodule

// File: tb/tb_dlx_fwd_scoreboard.sv
// tb_dlx_fwd_scoreboard: directed and random checks of the scoreboard against a list-of-producers model
module tb_dlx_fwd_scoreboard;
  localparam int RBITS = 5, DEPTH = 3, NSRC = 2, LOAD_RDY = 1, SELW = 2;
  logic clk = 1'b0, reset = 1'b1;
  logic id_valid = 0, id_dst_en = 0, id_is_load = 0, mem_busy = 0, flush = 0;
  logic [RBITS-1:0] id_dst = '0;
  logic [NSRC-1:0] id_src_en = '0;
  logic [NSRC*RBITS-1:0] id_src = '0;
  logic [NSRC*SELW-1:0] src_sel;
  logic stall, issue;
  logic [15:0] stall_cnt;
  int compared = 0, mismatched = 0;
  int md[DEPTH];
  bit ml[DEPTH];
  int m_cnt;

  dlx_fwd_scoreboard #(.RBITS(RBITS), .DEPTH(DEPTH), .NSRC(NSRC), .LOAD_RDY(LOAD_RDY), .SELW(SELW)) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_dst_en(id_dst_en), .id_dst(id_dst),
    .id_is_load(id_is_load), .id_src_en(id_src_en), .id_src(id_src), .mem_busy(mem_busy),
    .flush(flush), .src_sel(src_sel), .stall(stall), .issue(issue), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void ref_sel(input int s, input bit en, output int sel, output bit hz);
    sel = 0;
    hz = 0;
    if (en && s != 0)
      for (int k = 0; k < DEPTH; k++)
        if (md[k] == s) begin
          hz = ml[k] && k < LOAD_RDY;
          sel = hz ? 0 : k + 1;
          break;
        end
  endfunction

  task automatic do_reset();
    reset = 1; id_valid = 0; id_src_en = '0; mem_busy = 0; flush = 0;
    @(posedge clk); #1;
    reset = 0;
    for (int k = 0; k < DEPTH; k++) begin md[k] = 0; ml[k] = 0; end
    m_cnt = 0;
  endtask

  task automatic step(input bit v, input bit de, input int d, input bit ld, input bit [1:0] sen,
                      input int s0, input int s1, input bit mb, input bit fl, input string tag);
    int e0, e1;
    bit h0, h1, es, ei;
    id_valid = v; id_dst_en = de; id_dst = RBITS'(d); id_is_load = ld; id_src_en = sen;
    id_src = {RBITS'(s1), RBITS'(s0)}; mem_busy = mb; flush = fl;
    #1;
    ref_sel(s0, sen[0], e0, h0);
    ref_sel(s1, sen[1], e1, h1);
    es = v && (h0 || h1) && !fl;
    ei = v && !es && !mb && !fl;
    chk({tag, ".sel"}, 32'(src_sel), 32'({SELW'(e1), SELW'(e0)}));
    chk({tag, ".stall"}, 32'(stall), 32'(es));
    chk({tag, ".issue"}, 32'(issue), 32'(ei));
    chk({tag, ".cnt"}, 32'(stall_cnt), 32'(m_cnt));
    if (!mb) begin
      for (int k = DEPTH - 1; k > 0; k--) begin
        md[k] = (fl && k == 1) ? 0 : md[k-1];
        ml[k] = ml[k-1];
      end
      md[0] = (ei && de) ? d : 0;
      ml[0] = ld;
    end
    if (es && m_cnt < 65535) m_cnt++;
    @(posedge clk); #1;
  endtask

  initial begin
    @(posedge clk); #1;
    do_reset();
    #1;
    chk("reset.sel", 32'(src_sel), 0);
    chk("reset.stall", 32'(stall), 0);
    chk("reset.issue", 32'(issue), 0);
    chk("reset.cnt", 32'(stall_cnt), 0);
    // ALU back-to-back
    step(1, 1, 3, 0, 2'b00, 0, 0, 0, 0, "alu_issue");
    step(1, 0, 0, 0, 2'b01, 3, 0, 0, 0, "alu_fwd_ex");
    step(1, 0, 0, 0, 2'b01, 3, 0, 0, 0, "alu_fwd_mem");
    // load-use
    step(1, 1, 5, 1, 2'b00, 0, 0, 0, 0, "lw_issue");
    id_valid = 1; id_dst_en = 0; id_src_en = 2'b10; id_src = {5'd5, 5'd0}; #1;
    chk("lu.stall_now", 32'(stall), 1);
    step(1, 0, 0, 0, 2'b10, 0, 5, 0, 0, "lu_stall");
    chk("lu.cnt_after", 32'(stall_cnt), 1);
    chk("lu.sel1", 32'(src_sel[SELW +: SELW]), 2);
    chk("lu.issue", 32'(issue), 1);
    step(1, 0, 0, 0, 2'b10, 0, 5, 0, 0, "lu_go");
    // r0 never forwarded, youngest r7 wins
    step(1, 1, 7, 0, 2'b00, 0, 0, 0, 0, "r7a");
    step(1, 1, 9, 0, 2'b00, 0, 0, 0, 0, "r9");
    step(1, 1, 7, 0, 2'b00, 0, 0, 0, 0, "r7b");
    id_valid = 1; id_dst_en = 0; id_src_en = 2'b11; id_src = {5'd7, 5'd0}; #1;
    chk("young.sel", 32'(src_sel), 32'(4'b0100));
    step(1, 0, 0, 0, 2'b11, 0, 7, 0, 0, "young");
    // mem_busy freezes a pending load-use
    do_reset();
    step(1, 1, 5, 1, 2'b00, 0, 0, 0, 0, "mb_lw");
    for (int c = 0; c < 3; c++) step(1, 0, 0, 0, 2'b10, 0, 5, 1, 0, "mb_hold");
    chk("mb.cnt3", 32'(stall_cnt), 3);
    step(1, 0, 0, 0, 2'b10, 0, 5, 0, 0, "mb_release");
    step(1, 0, 0, 0, 2'b10, 0, 5, 0, 0, "mb_fwd");
    // flush squashes ID and the load in EX
    step(1, 1, 5, 1, 2'b00, 0, 0, 0, 0, "fl_lw");
    id_valid = 1; id_dst_en = 0; id_src_en = 2'b10; id_src = {5'd5, 5'd0}; flush = 1; #1;
    chk("fl.stall", 32'(stall), 0);
    chk("fl.issue", 32'(issue), 0);
    step(1, 0, 0, 0, 2'b10, 0, 5, 0, 1, "fl_cycle");
    chk("fl.sel_after", 32'(src_sel), 0);
    step(1, 0, 0, 0, 2'b10, 0, 5, 0, 0, "fl_after");
    // random traffic
    for (int n = 0; n < 400; n++)
      step($urandom_range(9) < 8, $urandom_range(1), $urandom_range(7), $urandom_range(2) == 0,
           2'($urandom_range(3)), $urandom_range(7), $urandom_range(7),
           $urandom_range(4) == 0, $urandom_range(9) == 0, "rand");
    // saturation under a frozen load-use, then reset
    step(1, 1, 6, 1, 2'b00, 0, 0, 0, 0, "sat_lw");
    id_valid = 1; id_dst_en = 0; id_src_en = 2'b01; id_src = {5'd0, 5'd6}; mem_busy = 1; flush = 0;
    repeat (70000) @(posedge clk);
    #1;
    chk("sat.cnt", 32'(stall_cnt), 32'hFFFF);
    chk("sat.stall", 32'(stall), 1);
    reset = 1;
    @(posedge clk); #1;
    reset = 0; mem_busy = 0; #1;
    chk("rst.cnt", 32'(stall_cnt), 0);
    chk("rst.sel", 32'(src_sel), 0);
    chk("rst.stall", 32'(stall), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/dlx_fwd_scoreboard.md
Name: dlx_fwd_scoreboard

Overview:
- Parametrised successor to the DLX ID-stage bypass/interlock logic.
- Tracks in-flight destination registers in a DEPTH-entry shadow pipeline (EX, MEM, WB, ...) that advances in lockstep with the datapath.
- Emits per-source forwarding selects for NSRC operands of the instruction in ID.
- Emits a load-use stall, honours memory back-pressure and branch flush, and keeps a saturating stall-cycle counter.

Parameters:
- RBITS, 5: register index width; register 0 is hard-wired zero and is never forwarded.
- DEPTH, 3: tracked stages after ID; entry 0 = EX, entry DEPTH-1 = last stage before register-file write.
- NSRC, 2: source operands per ID instruction.
- LOAD_RDY, 1: first entry index at which a load result is forwardable. Must satisfy 0 <= LOAD_RDY < DEPTH.
- SELW, clog2(DEPTH+1): width of one select field.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- id_valid  in  1  ID holds a real instruction
- id_dst_en  in  1  ID instruction writes a register
- id_dst  in  RBITS  ID destination register
- id_is_load  in  1  ID instruction is a load
- id_src_en  in  NSRC  per-source "operand is read"
- id_src  in  NSRC*RBITS  source registers, source i at bits [i*RBITS +: RBITS]
- mem_busy  in  1  memory back-pressure; freezes the whole pipeline
- flush  in  1  squash the ID instruction and entry 0 (EX)
- src_sel  out  NSRC*SELW  per-source select: 0 = register file, k+1 = forward from entry k
- stall  out  1  hold ID and PC, insert a bubble into EX
- issue  out  1  ID instruction enters EX this cycle
- stall_cnt  out  16  saturating count of cycles with stall=1

Behaviour:
- Clocking: single clock domain on clk. Reset is synchronous and active-high.
- Reset: all entries invalid, stall_cnt = 0. Outputs after reset: src_sel = 0, stall = 0, issue = 0.
- Entry state: each entry holds {vld, dst, is_load}. An entry with dst = 0 or dst_en = 0 is stored with vld = 0.
- Forwarding (combinational from ID inputs and entries):
  - For each source i with id_src_en[i] = 1 and id_src[i] != 0, find the lowest k (youngest producer) with entry[k].vld and entry[k].dst = id_src[i].
  - No match: src_sel[i] = 0.
  - Match, and entry[k].is_load with k < LOAD_RDY: hazard[i] = 1, src_sel[i] = 0.
  - Otherwise src_sel[i] = k+1.
  - An older match is never used when a younger one exists.
- Stall and issue:
  - stall = id_valid & |hazard & ~flush.
  - issue = id_valid & ~stall & ~mem_busy & ~flush.
- Sequential update, evaluated in this priority order:
  - reset: as above.
  - mem_busy = 1: all entries hold. flush is ignored while mem_busy = 1; the pipeline control re-asserts it.
  - Otherwise:
    - entry[k] <= entry[k-1] for k = 1..DEPTH-1.
    - entry[DEPTH-1] retires.
    - entry[0] <= issue ? {id_dst_en & (id_dst != 0), id_dst, id_is_load} : bubble.
    - flush = 1: entry[0] <= bubble, and additionally the current entry[0] is not shifted into entry[1] (it becomes a bubble).
- Latency: a producer issued in cycle t is forwardable from entry 0 in cycle t+1. A load is first forwardable in cycle t+1+LOAD_RDY, so a dependent instruction stalls LOAD_RDY cycles.
- stall_cnt: increments by 1 each cycle stall = 1, holding at 16'hFFFF. mem_busy cycles are not counted unless stall = 1.
- Simultaneous events:
  - stall together with mem_busy: no shift, stall still reported.
  - Two sources hitting different stages: each resolves independently.
  - Reset mid-stall clears the entries, so stall drops the next cycle.

Decomposition:
- dlx_defs: add the SEL_RF = 0 encoding and the entry-record field offsets.
- Sub-module dlx_fwd_match (one per source): priority-match of one source against all entries, producing {sel, hazard}.
- Top level holds the shift register, control and counter.

Test Plan:
- ALU back-to-back (defaults): add r3 issued, next ID reads r3 as src0 -> src_sel[0] = 1, stall = 0. One cycle later an unrelated ID reading r3 -> src_sel[0] = 2.
- Load-use: lw r5, then ID reads r5 as src1 -> stall = 1 for exactly 1 cycle, stall_cnt = 1. Next cycle src_sel[1] = 2, issue = 1.
- r0 and younger-wins: entries hold r7 at k=0 and k=2, and ID reads r0 and r7 -> src_sel = {sel1 = 1, sel0 = 0}.
- mem_busy held 3 cycles with a pending load-use -> entries frozen, stall = 1 for all 3 cycles, stall_cnt = 3, issue = 0.
- flush while a load to r5 sits in entry 0 and ID reads r5 -> stall = 0, issue = 0. Next cycle entries 0 and 1 are invalid and src_sel = 0.
- Saturation, then reset: force 70000 stall cycles -> stall_cnt = 16'hFFFF. Assert reset for 1 cycle -> stall_cnt = 0, all src_sel = 0.
